dm_access_unit: RTL and testbench

- Pipeline-side initiator for the data memory: accepts one load/store per operation from the M stage and drives a req/ack word-addressed memory port.
- Generates byte enables and lane-replicated write data, then extracts and sign/zero-extends load data.
- Stalls the pipeline until the memory responds; flags misaligned accesses and response timeouts.

---
 rtl/dm_pkg.sv | 93 +++++++++
 rtl/dm_load_ext.sv | 39 +++
 rtl/dm_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_dm_access_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Data-memory access shared definitions: op codes, FSM states,
// byte-enable constants and the store request builder.
package dm_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_EXC  = 2'd3
  } state_e;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE    = 4'b0001;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return (op >= OP_LW) && (op <= OP_SB);
  endfunction

  function automatic logic op_store(
    input logic [3:0] op
  );
    return (op == OP_SW) || (op == OP_SH) ||
           (op == OP_SB);
  endfunction

  function automatic logic op_word(
    input logic [3:0] op
  );
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_half(
    input logic [3:0] op
  );
    return (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_SH);
  endfunction

  // Stores replicate the data across every lane so the
  // byte enables alone decide which bytes land.
  function automatic mreq_t build_req(
    input logic [3:0]  op,
    input logic [1:0]  lane,
    input logic [31:0] wd
  );
    mreq_t r;
    r.we    = 1'b0;
    r.be    = BE_WORD;
    r.wdata = '0;
    unique case (1'b1)
      (op == OP_SW): begin
        r.we    = 1'b1;
        r.wdata = wd;
      end
      (op == OP_SH): begin
        r.we    = 1'b1;
        r.be    = lane[1] ? BE_HALF_HI
                          : BE_HALF_LO;
        r.wdata = {2{wd[15:0]}};
      end
      (op == OP_SB): begin
        r.we    = 1'b1;
        r.be    = BE_BYTE << lane;
        r.wdata = {4{wd[7:0]}};
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension.
// Ports: word_i read word, addr_i byte lane, op_i op code, result_o.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o
);

  logic [15:0] half;
  logic [7:0]  b8;

  always_comb begin
    half = addr_i[1] ? word_i[31:16]
                     : word_i[15:0];
    b8 = 8'h00;
    unique case (addr_i)
      2'd0: b8 = word_i[7:0];
      2'd1: b8 = word_i[15:8];
      2'd2: b8 = word_i[23:16];
      2'd3: b8 = word_i[31:24];
      default: b8 = 8'h00;
    endcase
  end

  always_comb begin
    result_o = word_i;
    unique case (op_i)
      OP_LH:  result_o = {{16{half[15]}}, half};
      OP_LHU: result_o = {16'h0000, half};
      OP_LB:  result_o = {{24{b8[7]}}, b8};
      OP_LBU: result_o = {24'h000000, b8};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// M-stage data memory initiator: req/ack word port, byte lanes,
// load extension, misalignment and timeout reporting.
// Ports: op_valid/op/addr/wdata from pipeline; stall, done, rdata,
// exc_adel, exc_ades, err_timeout back; m_* memory req/ack port.
module dm_access_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic              err_timeout,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-3:0] m_addr,
  output logic [3:0]        m_byteen,
  output logic [31:0]       m_wdata,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata
);

  localparam logic [3:0] CNT_LAST =
    4'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-3:0] maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       mwd_q, mwd_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic              tout_q, tout_d;

  logic        legal;
  logic        misal;
  logic        is_st;
  mreq_t       nreq;
  logic [31:0] ext;

  dm_load_ext u_ext (
    .word_i   (m_rdata),
    .addr_i   (lane_q),
    .op_i     (op_q),
    .result_o (ext)
  );

  assign legal = op_valid && op_legal(op);
  assign is_st = op_store(op);
  assign nreq  = build_req(op, addr[1:0], wdata);

  always_comb begin
    misal = 1'b0;
    if (op_word(op))
      misal = (addr[1:0] != 2'b00);
    else if (op_half(op))
      misal = addr[0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    lane_d  = lane_q;
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    be_d    = be_q;
    mwd_d   = mwd_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    adel_d  = 1'b0;
    ades_d  = 1'b0;
    tout_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (legal && misal) begin
          state_d = S_EXC;
          ades_d  = is_st;
          adel_d  = !is_st;
        end else if (legal) begin
          state_d = S_REQ;
          cnt_d   = '0;
          op_d    = op;
          lane_d  = addr[1:0];
          req_d   = 1'b1;
          we_d    = nreq.we;
          maddr_d = addr[ADDR_W-1:2];
          be_d    = nreq.be;
          mwd_d   = nreq.wdata;
        end
      end
      S_REQ: begin
        // ack beats a coincident timeout
        if (m_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          rdata_d = op_store(op_q) ? '0 : ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          tout_d  = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      lane_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      be_q    <= '0;
      mwd_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      be_q    <= be_d;
      mwd_q   <= mwd_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
      tout_q  <= tout_d;
    end
  end

  assign stall = legal &&
                 (state_q != S_DONE) &&
                 !(adel_q || ades_q);

  assign done        = done_q;
  assign rdata       = rdata_q;
  assign exc_adel    = adel_q;
  assign exc_ades    = ades_q;
  assign err_timeout = tout_q;
  assign m_req       = req_q;
  assign m_we        = we_q;
  assign m_addr      = maddr_q;
  assign m_byteen    = be_q;
  assign m_wdata     = mwd_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit: vector table of loads/stores
// plus hand sequences for exceptions, timeout and mid-op reset.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic        stall, done;
  logic [31:0] rdata;
  logic        exc_adel, exc_ades;
  logic        err_timeout;
  logic        m_req, m_we;
  logic [11:0] m_addr;
  logic [3:0]  m_byteen;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_access_unit #(.ADDR_W(14), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .op_valid    (op_valid),
    .op          (op),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .exc_adel    (exc_adel),
    .exc_ades    (exc_ades),
    .err_timeout (err_timeout),
    .m_req       (m_req),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_byteen    (m_byteen),
    .m_wdata     (m_wdata),
    .m_ack       (m_ack),
    .m_rdata     (m_rdata)
  );

  // dly = REQ cycle (1-based) on which ack is given; 0 = never
  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [13:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    logic        x_we;
    logic [3:0]  x_be;
    logic [11:0] x_ma;
    logic [31:0] x_mw;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h",
               nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int cyc = 0, reqs = 0, stalls = 0;
    int errs = 0, dcyc = 0, xreq;
    bit seen = 0;
    logic [31:0] rd = '0, mw = '0;
    logic [3:0] be = '0;
    logic we = 0, errd = 0;
    logic [11:0] ma = '0;
    @(negedge clk);
    op_valid = 1; op = v.op; addr = v.addr;
    wdata = v.wd; m_rdata = v.rd; m_ack = 0;
    while (!seen && cyc < 40) begin
      #1;
      cyc++;
      if (stall) stalls++;
      if (err_timeout) errs++;
      if (m_req) begin
        reqs++;
        if (reqs == 1) begin
          be = m_byteen; we = m_we;
          ma = m_addr; mw = m_wdata;
        end
        m_ack = (reqs == v.dly);
      end else begin
        m_ack = 0;
      end
      if (done) begin
        seen = 1; dcyc = cyc; rd = rdata;
        errd = err_timeout;
        op_valid = 0; m_ack = 0;
      end
      @(negedge clk);
    end
    xreq = (v.dly == 0) ? 15 : v.dly;
    chk({v.nm, ".done_seen"}, 32'(seen), 1);
    chk({v.nm, ".done_cyc"}, dcyc, xreq + 2);
    chk({v.nm, ".stall_cyc"}, stalls, xreq + 1);
    chk({v.nm, ".req_cyc"}, reqs, xreq);
    chk({v.nm, ".rdata"}, rd, v.x_rdata);
    chk({v.nm, ".err_at_done"}, 32'(errd),
        32'(v.x_err));
    chk({v.nm, ".err_pulses"}, errs,
        v.x_err ? 1 : 0);
    chk({v.nm, ".we"}, 32'(we), 32'(v.x_we));
    chk({v.nm, ".be"}, 32'(be), 32'(v.x_be));
    chk({v.nm, ".maddr"}, 32'(ma), 32'(v.x_ma));
    if (v.x_we)
      chk({v.nm, ".mwdata"}, mw, v.x_mw);
  endtask

  task automatic run_exc(input string nm,
                         input logic [3:0] o,
                         input logic [13:0] a,
                         input int x_s,
                         input int x_l);
    int ns = 0, nl = 0, nr = 0, nd = 0;
    @(negedge clk);
    op_valid = 1; op = o; addr = a;
    wdata = 32'h5555AAAA; m_ack = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (exc_ades) ns++;
      if (exc_adel) nl++;
      if (m_req) nr++;
      if (done) nd++;
      if (exc_ades || exc_adel) op_valid = 0;
      @(negedge clk);
    end
    op_valid = 0;
    chk({nm, ".ades_pulses"}, ns, x_s);
    chk({nm, ".adel_pulses"}, nl, x_l);
    chk({nm, ".req_cyc"}, nr, 0);
    chk({nm, ".done_cnt"}, nd, 0);
  endtask

  task automatic run_reset;
    int nd = 0;
    @(negedge clk);
    op_valid = 1; op = 4'd1; addr = 14'h030;
    m_rdata = 32'h11111111; m_ack = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.req_before", 32'(m_req), 1);
    reset = 1; op_valid = 0;
    @(negedge clk);
    #1;
    chk("rst.req_after", 32'(m_req), 0);
    chk("rst.stall_after", 32'(stall), 0);
    chk("rst.done_after", 32'(done), 0);
    @(negedge clk);
    reset = 0; m_ack = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (done || m_req) nd++;
      @(negedge clk);
    end
    m_ack = 0;
    chk("rst.idle_ack_ignored", nd, 0);
  endtask

  initial begin
    vt[0]  = '{"lw_0x010", 4'd1, 14'h010, 0,
      32'hDEADBEEF, 1, 0, 4'hF, 12'h004, 0,
      32'hDEADBEEF, 0};
    vt[1]  = '{"sh_0x006", 4'd7, 14'h006,
      32'h1234ABCD, 0, 4, 1, 4'hC, 12'h001,
      32'hABCDABCD, 0, 0};
    vt[2]  = '{"lb_0x003", 4'd4, 14'h003, 0,
      32'h80FFFF7F, 1, 0, 4'hF, 12'h000, 0,
      32'hFFFFFF80, 0};
    vt[3]  = '{"lbu_0x003", 4'd5, 14'h003, 0,
      32'h80FFFF7F, 1, 0, 4'hF, 12'h000, 0,
      32'h00000080, 0};
    vt[4]  = '{"lh_0x002", 4'd2, 14'h002, 0,
      32'h80FFFF7F, 1, 0, 4'hF, 12'h000, 0,
      32'hFFFF80FF, 0};
    vt[5]  = '{"lhu_0x000", 4'd3, 14'h000, 0,
      32'h80FFFF7F, 2, 0, 4'hF, 12'h000, 0,
      32'h0000FF7F, 0};
    vt[6]  = '{"sb_0x005", 4'd8, 14'h005,
      32'h000000A5, 0, 1, 1, 4'h2, 12'h001,
      32'hA5A5A5A5, 0, 0};
    vt[7]  = '{"sw_0x3ffc", 4'd6, 14'h3FFC,
      32'hCAFEF00D, 0, 3, 1, 4'hF, 12'hFFF,
      32'hCAFEF00D, 0, 0};
    vt[8]  = '{"lw_0x3ffc", 4'd1, 14'h3FFC, 0,
      32'h12345678, 1, 0, 4'hF, 12'hFFF, 0,
      32'h12345678, 0};
    vt[9]  = '{"sh_0x000", 4'd7, 14'h000,
      32'hFFFF8001, 0, 1, 1, 4'h3, 12'h000,
      32'h80018001, 0, 0};
    vt[10] = '{"lw_timeout", 4'd1, 14'h020, 0,
      32'h77777777, 0, 0, 4'hF, 12'h008, 0,
      32'h00000000, 1};
    vt[11] = '{"lw_ack_at_limit", 4'd1, 14'h024,
      0, 32'h0BADF00D, 15, 0, 4'hF, 12'h009, 0,
      32'h0BADF00D, 0};

    reset = 1; op_valid = 0; op = 0; addr = 0;
    wdata = 0; m_ack = 0; m_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.m_req", 32'(m_req), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.rdata", rdata, 0);
    chk("reset.m_byteen", 32'(m_byteen), 0);
    chk("reset.m_addr", 32'(m_addr), 0);
    chk("reset.exc", 32'({exc_adel, exc_ades,
        err_timeout}), 0);
    reset = 0;
    op_valid = 1; op = 4'd9;
    #1;
    chk("idle.illegal_op_stall", 32'(stall), 0);
    op_valid = 0;

    for (int i = 0; i < 12; i++)
      run_op(vt[i]);

    run_exc("sw_0x002", 4'd6, 14'h002, 1, 0);
    run_exc("lh_0x001", 4'd2, 14'h001, 0, 1);
    run_exc("lw_0x003", 4'd1, 14'h003, 0, 1);

    run_reset();
    run_op(vt[0]);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
